// File: rtl/axis_pkg.sv
// Shared types and constants for the AXI-Stream round-robin demux.
// Holds the FSM state enum, output-select codes and default widths.
package axis_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  localparam logic OUT1 = 1'b0;
  localparam logic OUT2 = 1'b1;

  localparam int DEF_DATA_WIDTH = 8;

endpackage

// File: rtl/axis_rr_demux_if.sv
// Valid/ready AXI-Stream beat bundle used between the demux and
// its output register slices.
interface axis_rr_demux_if
  import axis_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
);

  logic                  tvalid;
  logic                  tready;
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tlast;

  modport master (
    output tvalid,
    output tdata,
    output tlast,
    input  tready
  );

  modport slave (
    input  tvalid,
    input  tdata,
    input  tlast,
    output tready
  );

endinterface

// File: rtl/axis_reg_slice.sv
// Single-entry output register slice; accepts a load in the same
// cycle its held beat drains, so it sustains one beat per cycle.
module axis_reg_slice
  import axis_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  load_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  last_i,
  output logic                  free_o,
  axis_rr_demux_if.master       m
);

  logic                  valid_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  last_q;

  assign free_o = !valid_q || m.tready;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
      last_q  <= last_i;
    end else if (m.tready) begin
      valid_q <= 1'b0;
    end
  end

  assign m.tvalid = valid_q;
  assign m.tdata  = data_q;
  assign m.tlast  = last_q;

endmodule

// File: rtl/axis_rr_demux.sv
// 1:2 AXI-Stream packet demux with per-output register slices.
// Define AXIS_RR_DEMUX_ROUND_ROBIN_EN to alternate packets 1,2,1,...
module axis_rr_demux
  import axis_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  Aclk,
  input  logic                  Areset,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tdest,
  output logic                  m_axis_tvalid1,
  input  logic                  m_axis_tready1,
  output logic [DATA_WIDTH-1:0] m_axis_tdata1,
  output logic                  m_axis_tlast1,
  output logic                  m_axis_tvalid2,
  input  logic                  m_axis_tready2,
  output logic [DATA_WIDTH-1:0] m_axis_tdata2,
  output logic                  m_axis_tlast2,
  output logic [CNT_WIDTH-1:0]  pkt_cnt1,
  output logic [CNT_WIDTH-1:0]  pkt_cnt2
);

  axis_rr_demux_if #(.DATA_WIDTH(DATA_WIDTH)) o1_if ();
  axis_rr_demux_if #(.DATA_WIDTH(DATA_WIDTH)) o2_if ();

  state_e               state_q;
  logic                 lock_q;
  logic                 tgt;
  logic                 free1;
  logic                 free2;
  logic                 acc;
  logic [CNT_WIDTH-1:0] cnt1_q;
  logic [CNT_WIDTH-1:0] cnt2_q;

`ifdef AXIS_RR_DEMUX_ROUND_ROBIN_EN
  logic rr_q;
  logic unused_dest;

  assign unused_dest = s_axis_tdest;
  assign tgt = (state_q == BUSY) ? lock_q : rr_q;

  always_ff @(posedge Aclk or posedge Areset) begin
    if (Areset) begin
      rr_q <= OUT1;
    end else if (acc && s_axis_tlast) begin
      rr_q <= ~rr_q;
    end
  end
`else
  assign tgt = (state_q == BUSY) ? lock_q : s_axis_tdest;
`endif

  // Ready depends only on slot state and downstream ready, never on tvalid.
  assign s_axis_tready = !Areset && ((tgt == OUT1) ? free1 : free2);
  assign acc = s_axis_tvalid && s_axis_tready;

  axis_reg_slice #(.DATA_WIDTH(DATA_WIDTH)) u_slice1 (
    .clk_i  (Aclk),
    .rst_i  (Areset),
    .load_i (acc && (tgt == OUT1)),
    .data_i (s_axis_tdata),
    .last_i (s_axis_tlast),
    .free_o (free1),
    .m      (o1_if)
  );

  axis_reg_slice #(.DATA_WIDTH(DATA_WIDTH)) u_slice2 (
    .clk_i  (Aclk),
    .rst_i  (Areset),
    .load_i (acc && (tgt == OUT2)),
    .data_i (s_axis_tdata),
    .last_i (s_axis_tlast),
    .free_o (free2),
    .m      (o2_if)
  );

  always_ff @(posedge Aclk or posedge Areset) begin
    if (Areset) begin
      state_q <= IDLE;
      lock_q  <= OUT1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (acc && !s_axis_tlast) begin
            state_q <= BUSY;
            lock_q  <= tgt;
          end
        end
        BUSY: begin
          if (acc && s_axis_tlast) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge Aclk or posedge Areset) begin
    if (Areset) begin
      cnt1_q <= '0;
      cnt2_q <= '0;
    end else begin
      if (o1_if.tvalid && o1_if.tready && o1_if.tlast) begin
        cnt1_q <= cnt1_q + CNT_WIDTH'(1);
      end
      if (o2_if.tvalid && o2_if.tready && o2_if.tlast) begin
        cnt2_q <= cnt2_q + CNT_WIDTH'(1);
      end
    end
  end

  assign o1_if.tready   = m_axis_tready1;
  assign o2_if.tready   = m_axis_tready2;
  assign m_axis_tvalid1 = o1_if.tvalid;
  assign m_axis_tdata1  = o1_if.tdata;
  assign m_axis_tlast1  = o1_if.tlast;
  assign m_axis_tvalid2 = o2_if.tvalid;
  assign m_axis_tdata2  = o2_if.tdata;
  assign m_axis_tlast2  = o2_if.tlast;
  assign pkt_cnt1       = cnt1_q;
  assign pkt_cnt2       = cnt2_q;

endmodule

// File: tb/tb_axis_rr_demux.sv
// Directed bench for axis_rr_demux: routing, lock, stall, reset,
// independence of outputs and (with the macro) round-robin order.
module tb_axis_rr_demux;
  import axis_pkg::*;

  logic Aclk = 1'b0;
  logic Areset = 1'b1;
  always #5 Aclk = ~Aclk;

  axis_rr_demux_if #(.DATA_WIDTH(8)) sin ();

  logic        s_tdest;
  logic        rdy1;
  logic        rdy2;
  logic        v1;
  logic        v2;
  logic [7:0]  d1;
  logic [7:0]  d2;
  logic        l1;
  logic        l2;
  logic [15:0] cnt1;
  logic [15:0] cnt2;

  int total = 0;
  int bad = 0;

  axis_rr_demux #(.DATA_WIDTH(8), .CNT_WIDTH(16)) dut (
    .Aclk           (Aclk),
    .Areset         (Areset),
    .s_axis_tvalid  (sin.tvalid),
    .s_axis_tready  (sin.tready),
    .s_axis_tdata   (sin.tdata),
    .s_axis_tlast   (sin.tlast),
    .s_axis_tdest   (s_tdest),
    .m_axis_tvalid1 (v1),
    .m_axis_tready1 (rdy1),
    .m_axis_tdata1  (d1),
    .m_axis_tlast1  (l1),
    .m_axis_tvalid2 (v2),
    .m_axis_tready2 (rdy2),
    .m_axis_tdata2  (d2),
    .m_axis_tlast2  (l2),
    .pkt_cnt1       (cnt1),
    .pkt_cnt2       (cnt2)
  );

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Aclk);
    #1;
  endtask

  // Present one beat, wait (bounded) for ready, then clock it in.
  task automatic send(logic [7:0] d, logic l, logic dst);
    int n;
    n = 0;
    sin.tvalid = 1'b1;
    sin.tdata  = d;
    sin.tlast  = l;
    s_tdest    = dst;
    #1;
    while (!sin.tready && n < 40) begin
      tick();
      n++;
    end
    chk("s_ready", {31'd0, sin.tready}, 32'd1);
    tick();
  endtask

  task automatic idle();
    sin.tvalid = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    sin.tvalid = 1'b1;
    sin.tdata  = 8'hAA;
    sin.tlast  = 1'b0;
    s_tdest    = 1'b0;
    rdy1       = 1'b1;
    rdy2       = 1'b1;
    Areset     = 1'b1;

    repeat (5) begin
      tick();
      chk("rst_ready", {31'd0, sin.tready}, 32'd0);
      chk("rst_v1", {31'd0, v1}, 32'd0);
      chk("rst_v2", {31'd0, v2}, 32'd0);
      chk("rst_cnt1", {16'd0, cnt1}, 32'd0);
      chk("rst_cnt2", {16'd0, cnt2}, 32'd0);
    end
    sin.tvalid = 1'b0;
    Areset = 1'b0;
    tick();

`ifdef AXIS_RR_DEMUX_ROUND_ROBIN_EN
    for (int p = 0; p < 3; p++) begin
      for (int b = 0; b < 2; b++) begin
        send(8'(8'h70 + 2 * p + b), (b == 1), 1'b1);
        if (p == 1) begin
          chk("rr_v2", {31'd0, v2}, 32'd1);
          chk("rr_d2", {24'd0, d2}, 32'(8'h70 + 2 * p + b));
          chk("rr_v1", {31'd0, v1}, 32'd0);
        end else begin
          chk("rr_v1", {31'd0, v1}, 32'd1);
          chk("rr_d1", {24'd0, d1}, 32'(8'h70 + 2 * p + b));
          chk("rr_v2", {31'd0, v2}, 32'd0);
        end
      end
    end
    idle();
    chk("rr_cnt1", {16'd0, cnt1}, 32'd2);
    chk("rr_cnt2", {16'd0, cnt2}, 32'd1);
`else
    for (int i = 1; i <= 6; i++) begin
      send(8'(i), (i == 6), 1'b0);
      chk("a_v1", {31'd0, v1}, 32'd1);
      chk("a_d1", {24'd0, d1}, 32'(i));
      chk("a_l1", {31'd0, l1}, 32'(i == 6));
      chk("a_v2", {31'd0, v2}, 32'd0);
    end
    idle();
    chk("a_cnt1", {16'd0, cnt1}, 32'd1);
    chk("a_v1_drain", {31'd0, v1}, 32'd0);
    chk("a_cnt2", {16'd0, cnt2}, 32'd0);

    for (int i = 1; i <= 6; i++) begin
      send(8'(8'h10 + i), (i == 6), (i == 1) ? 1'b1 : 1'(i % 2));
      chk("b_v2", {31'd0, v2}, 32'd1);
      chk("b_d2", {24'd0, d2}, 32'(8'h10 + i));
      chk("b_v1", {31'd0, v1}, 32'd0);
    end
    idle();
    chk("b_cnt2", {16'd0, cnt2}, 32'd1);
    chk("b_cnt1", {16'd0, cnt1}, 32'd1);

    send(8'h21, 1'b0, 1'b1);
    send(8'h22, 1'b0, 1'b1);
    chk("c_d2_pre", {24'd0, d2}, 32'h22);
    rdy2 = 1'b0;
    sin.tvalid = 1'b1;
    sin.tdata  = 8'h23;
    sin.tlast  = 1'b0;
    s_tdest    = 1'b0;
    repeat (4) begin
      #1;
      chk("c_stall_ready", {31'd0, sin.tready}, 32'd0);
      tick();
      chk("c_hold_v2", {31'd0, v2}, 32'd1);
      chk("c_hold_d2", {24'd0, d2}, 32'h22);
    end
    rdy2 = 1'b1;
    for (int i = 3; i <= 6; i++) begin
      send(8'(8'h20 + i), (i == 6), 1'b0);
      chk("c_v2", {31'd0, v2}, 32'd1);
      chk("c_d2", {24'd0, d2}, 32'(8'h20 + i));
      chk("c_v1", {31'd0, v1}, 32'd0);
    end
    idle();
    chk("c_cnt2", {16'd0, cnt2}, 32'd2);

    rdy1 = 1'b0;
    send(8'h51, 1'b1, 1'b0);
    chk("f_v1", {31'd0, v1}, 32'd1);
    chk("f_d1", {24'd0, d1}, 32'h51);
    chk("f_l1", {31'd0, l1}, 32'd1);
    send(8'h61, 1'b1, 1'b1);
    chk("f_v1_hold", {31'd0, v1}, 32'd1);
    chk("f_d1_hold", {24'd0, d1}, 32'h51);
    chk("f_v2", {31'd0, v2}, 32'd1);
    chk("f_d2", {24'd0, d2}, 32'h61);
    sin.tvalid = 1'b1;
    sin.tdata  = 8'h52;
    sin.tlast  = 1'b1;
    s_tdest    = 1'b0;
    #1;
    chk("f_block_ready", {31'd0, sin.tready}, 32'd0);
    sin.tvalid = 1'b0;
    rdy1 = 1'b1;
    tick();
    chk("f_cnt1", {16'd0, cnt1}, 32'd2);
    chk("f_cnt2", {16'd0, cnt2}, 32'd3);
    chk("f_v1_drain", {31'd0, v1}, 32'd0);
    chk("f_v2_drain", {31'd0, v2}, 32'd0);

    send(8'h31, 1'b0, 1'b1);
    send(8'h32, 1'b0, 1'b1);
    send(8'h33, 1'b0, 1'b1);
    chk("d_d2_pre", {24'd0, d2}, 32'h33);
    sin.tvalid = 1'b0;
    Areset = 1'b1;
    #1;
    chk("d_rst_v2", {31'd0, v2}, 32'd0);
    chk("d_rst_v1", {31'd0, v1}, 32'd0);
    chk("d_rst_cnt1", {16'd0, cnt1}, 32'd0);
    chk("d_rst_cnt2", {16'd0, cnt2}, 32'd0);
    chk("d_rst_ready", {31'd0, sin.tready}, 32'd0);
    Areset = 1'b0;
    send(8'h41, 1'b0, 1'b0);
    chk("d_v1", {31'd0, v1}, 32'd1);
    chk("d_d1", {24'd0, d1}, 32'h41);
    chk("d_v2", {31'd0, v2}, 32'd0);
    send(8'h42, 1'b1, 1'b1);
    chk("d_lock_d1", {24'd0, d1}, 32'h42);
    chk("d_lock_l1", {31'd0, l1}, 32'd1);
    chk("d_lock_v2", {31'd0, v2}, 32'd0);
    idle();
    chk("d_cnt1", {16'd0, cnt1}, 32'd1);
    chk("d_cnt2", {16'd0, cnt2}, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
